// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt scheduler: edge-latched pending, masked priority select, bus register window
// Optional feature macro: IRQ_SCHED_ROUND_ROBIN_EN (rotating priority; default is fixed lowest-index-first).
module irq_sched #(
    parameter int              NSRC      = 4,
    parameter logic [63:0]     BASE_ADDR = 64'h8000_0020,
    parameter int              TIMEOUT   = 255,
    parameter logic [NSRC-1:0] EN_RESET  = '1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    output logic [3:0]      interrupt_vector,
    input  logic            interrupt_done,
    input  logic [63:0]     bus_address,
    input  logic [63:0]     bus_write_data,
    input  logic            bus_write_enable,
    input  logic            bus_read_enable,
    output logic [63:0]     bus_read_data,
    output logic            irq_active,
    output logic            irq_timeout
);
    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] src_q, pending_q, enable_q;
    logic [NSRC-1:0] edge_det, cand, clr;
    logic [3:0]      cur_q, cur_d, vec_d, sel;
    logic [15:0]     cnt_q, cnt_d;
    logic            to_set, served;
    logic            hit_pend, hit_en, hit_st;
    logic [63:0]     rd_mux;
    logic            unused_wdata;

    assign edge_det   = irq_src & ~src_q;
    assign cand       = pending_q & enable_q;
    assign irq_active = (state_q == ASSERT);

    assign hit_pend = (bus_address == BASE_ADDR);
    assign hit_en   = (bus_address == BASE_ADDR + 64'h8);
    assign hit_st   = (bus_address == BASE_ADDR + 64'h10);
    assign unused_wdata = ^bus_write_data;

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    logic [3:0] last_q;
    logic [4:0] dist, best_dist;

    // Pick the candidate with the smallest rotational distance past the last-serviced index.
    always_comb begin
        sel       = '0;
        dist      = '0;
        best_dist = 5'h1f;
        for (int i = 0; i < NSRC; i++) begin
            dist = 5'(i) + 5'(NSRC) - 5'(last_q) - 5'd1;
            if (dist >= 5'(NSRC))
                dist = dist - 5'(NSRC);
            if (cand[i] && (dist < best_dist)) begin
                best_dist = dist;
                sel       = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_q <= 4'(NSRC - 1);
        else if (served)
            last_q <= cur_q;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (cand[i])
                sel = 4'(i);
    end
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        vec_d   = interrupt_vector;
        clr     = '0;
        to_set  = 1'b0;
        served  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    cur_d   = sel;
                    vec_d   = sel + 4'd1;
                    cnt_d   = 16'(TIMEOUT - 1);
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                // Done wins over an expiring counter in the same cycle.
                if (interrupt_done) begin
                    clr     = (NSRC)'(1) << cur_q;
                    vec_d   = 4'd0;
                    served  = 1'b1;
                    state_d = GAP;
                end else if (cnt_q == 16'd0) begin
                    to_set  = 1'b1;
                    vec_d   = 4'd0;
                    served  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        if (hit_pend)
            rd_mux[NSRC-1:0] = pending_q;
        else if (hit_en)
            rd_mux[NSRC-1:0] = enable_q;
        else if (hit_st)
            rd_mux = {55'd0, irq_timeout, interrupt_vector, 3'd0, irq_active};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            src_q            <= '0;
            pending_q        <= '0;
            enable_q         <= EN_RESET;
            cur_q            <= '0;
            cnt_q            <= '0;
            interrupt_vector <= '0;
            irq_timeout      <= 1'b0;
            bus_read_data    <= '0;
        end else begin
            state_q          <= state_d;
            src_q            <= irq_src;
            // A new edge on a bit being cleared keeps it set.
            pending_q        <= (pending_q & ~clr) | edge_det;
            cur_q            <= cur_d;
            cnt_q            <= cnt_d;
            interrupt_vector <= vec_d;
            if (bus_write_enable && hit_en)
                enable_q <= bus_write_data[NSRC-1:0];
            if (to_set)
                irq_timeout <= 1'b1;
            else if (bus_write_enable && hit_st && bus_write_data[8])
                irq_timeout <= 1'b0;
            bus_read_data <= bus_read_enable ? rd_mux : 64'd0;
        end
    end
endmodule

// File: tb/tb_irq_sched.sv
// tb/tb_irq_sched.sv - randomized and directed bench for irq_sched against a behavioural model
module tb_irq_sched;
    localparam int          NSRC = 4;
    localparam int          TO   = 8;
    localparam logic [63:0] BASE = 64'h8000_0020;
    localparam int          MASK = (1 << NSRC) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NSRC-1:0] irq_src = '0;
    logic            interrupt_done = 1'b0;
    logic [63:0]     bus_address = '0;
    logic [63:0]     bus_write_data = '0;
    logic            bus_write_enable = 1'b0;
    logic            bus_read_enable = 1'b0;
    logic [3:0]      interrupt_vector;
    logic [63:0]     bus_read_data;
    logic            irq_active;
    logic            irq_timeout;

    irq_sched #(.NSRC(NSRC), .BASE_ADDR(BASE), .TIMEOUT(TO), .EN_RESET(4'hF)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src),
        .interrupt_vector(interrupt_vector), .interrupt_done(interrupt_done),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
        .bus_read_data(bus_read_data), .irq_active(irq_active), .irq_timeout(irq_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: service phase 0 = waiting, 1 = presenting a vector, 2 = forced blank cycle.
    int          m_prev, m_pend, m_en, m_phase, m_cur, m_age, m_last, m_vec;
    bit          m_tflag;
    logic [63:0] m_rd;

    function automatic int pick_src(input int cand, input int last);
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
        for (int k = 1; k <= NSRC; k++) begin
            int i = (last + k) % NSRC;
            if (cand[i]) return i;
        end
`else
        for (int i = 0; i < NSRC; i++)
            if (cand[i]) return i;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_en = MASK; m_phase = 0; m_cur = 0;
        m_age = 0; m_last = NSRC - 1; m_vec = 0; m_tflag = 0; m_rd = '0;
    endtask

    task automatic model_step();
        int          edges, clr, cand;
        bit          set_to;
        logic [63:0] rd;
        rd = '0; clr = 0; set_to = 0;
        if (bus_read_enable) begin
            if (bus_address == BASE)             rd = 64'(m_pend);
            else if (bus_address == BASE + 8)    rd = 64'(m_en);
            else if (bus_address == BASE + 16)   rd = {55'd0, m_tflag, 4'(m_vec), 3'd0, m_phase == 1};
        end
        edges = int'(irq_src) & ~m_prev & MASK;
        case (m_phase)
            0: begin
                cand = m_pend & m_en;
                if (cand != 0) begin
                    m_cur = pick_src(cand, m_last);
                    m_vec = m_cur + 1; m_age = 0; m_phase = 1;
                end
            end
            1: begin
                if (interrupt_done) begin
                    clr = 1 << m_cur; m_vec = 0; m_phase = 2; m_last = m_cur;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        set_to = 1; m_vec = 0; m_phase = 2; m_last = m_cur;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        if (bus_write_enable && bus_address == BASE + 8) m_en = int'(bus_write_data[NSRC-1:0]);
        if (bus_write_enable && bus_address == BASE + 16 && bus_write_data[8]) m_tflag = 0;
        if (set_to) m_tflag = 1;
        m_pend = (m_pend & ~clr) | edges;
        m_prev = int'(irq_src);
        m_rd   = rd;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset(); else model_step();
        @(negedge clk);
        check("m_vec", 64'(interrupt_vector), 64'(m_vec));
        check("m_act", 64'(irq_active), 64'(m_phase == 1));
        check("m_to",  64'(irq_timeout), 64'(m_tflag));
        check("m_rd",  bus_read_data, m_rd);
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
        bus_address = a; bus_write_data = d; bus_write_enable = 1'b1;
        cycle();
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
        bus_address = a; bus_read_enable = 1'b1;
        cycle();
        bus_read_enable = 1'b0;
        d = bus_read_data;
    endtask

    task automatic pulse_done();
        interrupt_done = 1'b1;
        cycle();
        interrupt_done = 1'b0;
    endtask

    task automatic wait_vec(input logic [3:0] v, input string tag);
        int n = 0;
        while (interrupt_vector != v && n < 50) begin
            cycle();
            n++;
        end
        check(tag, 64'(interrupt_vector), 64'(v));
    endtask

    initial begin
        logic [63:0] rd;
        int          n;
        logic [63:0] addrs [5];
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        check("rst_vec", 64'(interrupt_vector), 64'd0);
        check("rst_rd", bus_read_data, 64'd0);
        reset = 1'b1;
        cycle(); cycle();

        // Single source, serviced by done, no re-assert.
        irq_src = 4'b0001;
        cycle();
        check("s1_n", 64'(interrupt_vector), 64'd0);
        cycle();
        check("s1_vec", 64'(interrupt_vector), 64'd1);
        irq_src = '0;
        repeat (3) cycle();
        pulse_done();
        check("s1_drop", 64'(interrupt_vector), 64'd0);
        bus_read(BASE, rd);
        check("s1_pend", rd, 64'd0);
        repeat (3) cycle();
        check("s1_quiet", 64'(interrupt_vector), 64'd0);

        // Two simultaneous sources.
        irq_src = 4'b0110;
        wait_vec(4'd2, "s2_first");
        pulse_done();
        check("s2_drop", 64'(interrupt_vector), 64'd0);
        cycle();
        check("s2_gap", 64'(interrupt_vector), 64'd0);
        cycle();
        check("s2_second", 64'(interrupt_vector), 64'd3);
        pulse_done();
        irq_src = '0;
        repeat (3) cycle();

        // Timeout without done.
        irq_src = 4'b1000;
        wait_vec(4'd4, "s3_vec");
        n = 0;
        while (interrupt_vector == 4'd4 && n < 40) begin
            n++;
            cycle();
        end
        check("s3_len", 64'(n), 64'(TO));
        check("s3_flag", 64'(irq_timeout), 64'd1);
        bus_read(BASE + 16, rd);
        check("s3_status", rd, 64'h100);
        cycle();
        check("s3_reassert", 64'(interrupt_vector), 64'd4);
        pulse_done();
        irq_src = '0;
        bus_write(BASE + 16, 64'h100);
        check("s3_clear", 64'(irq_timeout), 64'd0);
        repeat (2) cycle();

        // Masked source stays pending until enabled.
        bus_write(BASE + 8, 64'h0);
        irq_src = 4'b0001;
        repeat (4) cycle();
        check("s4_masked", 64'(interrupt_vector), 64'd0);
        bus_read(BASE, rd);
        check("s4_pend", rd, 64'h1);
        bus_write(BASE + 8, 64'h1);
        check("s4_pre", 64'(interrupt_vector), 64'd0);
        cycle();
        check("s4_vec", 64'(interrupt_vector), 64'd1);
        irq_src = '0;
        pulse_done();
        repeat (2) cycle();

        // Re-request from the source in service, coincident with done.
        irq_src = 4'b0001;
        wait_vec(4'd1, "s5_vec");
        irq_src = '0;
        cycle();
        irq_src = 4'b0001;
        interrupt_done = 1'b1;
        cycle();
        interrupt_done = 1'b0;
        check("s5_drop", 64'(interrupt_vector), 64'd0);
        bus_read(BASE, rd);
        check("s5_pend", rd, 64'h1);
        cycle();
        check("s5_again", 64'(interrupt_vector), 64'd1);
        pulse_done();
        irq_src = '0;
        repeat (2) cycle();

        // Randomized traffic.
        bus_write(BASE + 8, 64'hF);
        addrs[0] = BASE; addrs[1] = BASE + 8; addrs[2] = BASE + 16; addrs[3] = BASE + 24;
        for (int c = 0; c < 1500; c++) begin
            int r;
            addrs[4] = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
            interrupt_done   = ($urandom_range(0, 5) == 0);
            r                = $urandom_range(0, 9);
            bus_read_enable  = (r < 4) || (r == 9);
            bus_write_enable = (r >= 7);
            bus_address      = addrs[$urandom_range(0, 4)];
            bus_write_data   = {$urandom, $urandom};
            cycle();
        end
        bus_read_enable = 1'b0; bus_write_enable = 1'b0; interrupt_done = 1'b0;

        // Asynchronous reset while a vector is presented.
        bus_write(BASE + 8, 64'hF);
        irq_src = '0;
        interrupt_done = 1'b1;
        repeat (20) cycle();
        interrupt_done = 1'b0;
        cycle();
        irq_src = 4'b0010;
        wait_vec(4'd2, "s7_vec");
        #2 reset = 1'b0;
        #1;
        check("s7_async_vec", 64'(interrupt_vector), 64'd0);
        check("s7_async_act", 64'(irq_active), 64'd0);
        model_reset();
        irq_src = '0;
        @(negedge clk);
        cycle();
        reset = 1'b1;
        cycle();
        bus_read(BASE, rd);
        check("s7_pend", rd, 64'd0);
        bus_read(BASE + 16, rd);
        check("s7_status", rd, 64'd0);
        bus_read(BASE + 8, rd);
        check("s7_enable", rd, 64'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
